// File: rtl/autocorr_pkg.sv
// Shared types and elaboration helpers for the block autocorrelator.
package autocorr_pkg;

    typedef enum logic {ACCUM, HOLD} in_state_t;
    typedef enum logic {EMPTY, STREAM} out_state_t;

    // Ceiling log2, floored at 1 so that it can always be used as a vector width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < longint'(v)) begin
            x = x << 1;
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic bit acf_w_ok(input int unsigned sample_w,
                                    input int unsigned block_size,
                                    input int unsigned acf_w);
        return acf_w >= 2 * sample_w + clog2(block_size);
    endfunction

endpackage

// File: rtl/autocorr_mac_lane.sv
// One autocorrelation lag: signed multiply, sign-extend, wrap-around accumulate.
// Optional product register stage when AUTOCORR_PIPE_EN is defined.
module autocorr_mac_lane
    import autocorr_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ACF_W    = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       load,
    input  logic                       clr,
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [SAMPLE_W-1:0] b,
    output logic signed [ACF_W-1:0]    acc
);

    localparam int unsigned PROD_W = 2 * SAMPLE_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACF_W-1:0]  prod_ext;
    logic                     acc_en;

    assign prod = PROD_W'(a) * PROD_W'(b);

`ifdef AUTOCORR_PIPE_EN
    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else if (en) begin
            prod_v <= load;
            if (load)
                prod_q <= prod;
        end
    end

    assign prod_ext = ACF_W'(prod_q);
    assign acc_en   = prod_v;
`else
    assign prod_ext = ACF_W'(prod);
    assign acc_en   = load;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en) begin
            if (clr)
                acc <= '0;
            else if (acc_en)
                acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/block_autocorrelator.sv
// Streaming block autocorrelator: lags 0..MAX_LAG, double-buffered result bank.
// Define AUTOCORR_PIPE_EN to add a product register stage (HOLD lasts two cycles).
module block_autocorrelator
    import autocorr_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned MAX_LAG    = 12,
    parameter int unsigned BLOCK_SIZE = 4096,
    parameter int unsigned ACF_W      = 48
) (
    input  logic                               iClock,
    input  logic                               iReset_n,
    input  logic                               iEnable,
    input  logic signed [SAMPLE_W-1:0]         iSample,
    input  logic                               iValid,
    input  logic                               iLast,
    output logic                               oReady,
    output logic signed [ACF_W-1:0]            oACF,
    output logic [clog2(MAX_LAG+1)-1:0]        oACFLag,
    output logic                               oACFValid,
    output logic                               oACFLast,
    input  logic                               iACFReady
);

    localparam int unsigned LAG_W = clog2(MAX_LAG + 1);
    localparam int unsigned CNT_W = clog2(BLOCK_SIZE);

    if (!acf_w_ok(SAMPLE_W, BLOCK_SIZE, ACF_W)) begin : g_acf_w_check
        $error("ACF_W too narrow for SAMPLE_W and BLOCK_SIZE");
    end

    in_state_t                in_q, in_d;
    out_state_t               out_q, out_d;
    logic                     started;
    logic [CNT_W-1:0]         cnt;
    logic signed [SAMPLE_W-1:0] dly  [1:MAX_LAG];
    logic signed [ACF_W-1:0]  acc  [0:MAX_LAG];
    logic signed [ACF_W-1:0]  bank [0:MAX_LAG];
    logic [LAG_W-1:0]         lag;
    logic                     accept, block_end, drained, xfer, beat_done, lag_last;

    // started keeps oReady low until the first enabled edge after reset.
    assign oReady    = started && (in_q == ACCUM);
    assign accept    = iEnable && iValid && oReady;
    assign block_end = accept && (iLast || (cnt == CNT_W'(BLOCK_SIZE - 1)));
    assign lag_last  = (lag == LAG_W'(MAX_LAG));
    assign beat_done = iEnable && iACFReady && (out_q == STREAM);

`ifdef AUTOCORR_PIPE_EN
    logic pipe_pend;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n)
            pipe_pend <= 1'b0;
        else if (iEnable)
            pipe_pend <= accept;
    end

    assign drained = !pipe_pend;
`else
    assign drained = 1'b1;
`endif

    // Registered out_q means a bank freed on this edge is only seen next cycle.
    assign xfer = iEnable && (in_q == HOLD) && drained && (out_q == EMPTY);

    always_comb begin
        in_d = in_q;
        case (in_q)
            ACCUM:   if (block_end) in_d = HOLD;
            HOLD:    if (xfer)      in_d = ACCUM;
            default:                in_d = ACCUM;
        endcase
    end

    always_comb begin
        out_d = out_q;
        case (out_q)
            EMPTY:   if (xfer)                  out_d = STREAM;
            STREAM:  if (beat_done && lag_last) out_d = EMPTY;
            default:                            out_d = EMPTY;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            in_q    <= ACCUM;
            out_q   <= EMPTY;
            started <= 1'b0;
        end else if (iEnable) begin
            in_q    <= in_d;
            out_q   <= out_d;
            started <= 1'b1;
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            cnt <= '0;
            for (int unsigned k = 1; k <= MAX_LAG; k++)
                dly[k] <= '0;
        end else if (iEnable) begin
            if (xfer) begin
                cnt <= '0;
                for (int unsigned k = 1; k <= MAX_LAG; k++)
                    dly[k] <= '0;
            end else if (accept) begin
                cnt    <= cnt + 1'b1;
                dly[1] <= iSample;
                for (int unsigned k = 2; k <= MAX_LAG; k++)
                    dly[k] <= dly[k-1];
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            lag <= '0;
            for (int unsigned k = 0; k <= MAX_LAG; k++)
                bank[k] <= '0;
        end else if (iEnable) begin
            if (xfer) begin
                lag <= '0;
                for (int unsigned k = 0; k <= MAX_LAG; k++)
                    bank[k] <= acc[k];
            end else if (beat_done) begin
                lag <= lag_last ? '0 : lag + 1'b1;
            end
        end
    end

    assign oACFValid = (out_q == STREAM);
    assign oACF      = oACFValid ? bank[lag] : '0;
    assign oACFLag   = lag;
    assign oACFLast  = oACFValid && lag_last;

    for (genvar k = 0; k <= MAX_LAG; k++) begin : g_lane
        logic signed [SAMPLE_W-1:0] tap;

        if (k == 0) begin : g_tap0
            assign tap = iSample;
        end else begin : g_tapk
            assign tap = dly[k];
        end

        autocorr_mac_lane #(
            .SAMPLE_W (SAMPLE_W),
            .ACF_W    (ACF_W)
        ) u_lane (
            .clk   (iClock),
            .rst_n (iReset_n),
            .en    (iEnable),
            .load  (accept),
            .clr   (xfer),
            .a     (iSample),
            .b     (tap),
            .acc   (acc[k])
        );
    end

endmodule

// File: tb/tb_block_autocorrelator.sv
// Directed self-checking bench for block_autocorrelator (default parameters).
// Bubble expectations follow AUTOCORR_PIPE_EN when it is defined.
module tb_block_autocorrelator;

    logic               iClock = 1'b0;
    logic               iReset_n;
    logic               iEnable;
    logic signed [15:0] iSample;
    logic               iValid;
    logic               iLast;
    logic               oReady;
    logic signed [47:0] oACF;
    logic [3:0]         oACFLag;
    logic               oACFValid;
    logic               oACFLast;
    logic               iACFReady;

    int vectors = 0;
    int fails   = 0;
    logic signed [63:0] ev [13];

    block_autocorrelator #(
        .SAMPLE_W   (16),
        .MAX_LAG    (12),
        .BLOCK_SIZE (4096),
        .ACF_W      (48)
    ) dut (
        .iClock    (iClock),
        .iReset_n  (iReset_n),
        .iEnable   (iEnable),
        .iSample   (iSample),
        .iValid    (iValid),
        .iLast     (iLast),
        .oReady    (oReady),
        .oACF      (oACF),
        .oACFLag   (oACFLag),
        .oACFValid (oACFValid),
        .oACFLast  (oACFLast),
        .iACFReady (iACFReady)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ev(input longint a0, input longint a1, input longint a2, input longint a3);
        for (int k = 0; k < 13; k++) ev[k] = 0;
        ev[0] = a0; ev[1] = a1; ev[2] = a2; ev[3] = a3;
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic send(input int s, input bit last);
        int g;
        g = 0;
        iSample = 16'(s);
        iLast   = last;
        iValid  = 1'b1;
        while (!oReady && g < 200) begin
            step();
            g++;
        end
        chk("send_ready", logic'(g < 200), 1);
        step();
        iValid = 1'b0;
        iLast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        iACFReady = 1'b1;
        while (!oACFValid && g < 100) begin
            step();
            g++;
        end
        chk({tag, "_valid"}, oACFValid, 1);
        for (int k = 0; k <= 12; k++) begin
            chk($sformatf("%s_lag%0d", tag, k), oACFLag, k);
            chk($sformatf("%s_acf%0d", tag, k), oACF, ev[k]);
            chk($sformatf("%s_last%0d", tag, k), oACFLast, logic'(k == 12));
            step();
        end
        chk({tag, "_empty"}, oACFValid, 0);
    endtask

    initial begin
        iReset_n = 1'b0; iEnable = 1'b1; iSample = '0;
        iValid = 1'b0; iLast = 1'b0; iACFReady = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_ready", oReady, 0);
        chk("rst_valid", oACFValid, 0);
        chk("rst_acf", oACF, 0);
        chk("rst_lag", oACFLag, 0);
        chk("rst_last", oACFLast, 0);
        iReset_n = 1'b1;
        step();
        chk("ready_after_rst", oReady, 1);

        // 1,2,3,4 with iLast; bubble and transfer timing
        iACFReady = 1'b1;
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        chk("t1_hold_ready", oReady, 0);
        chk("t1_hold_valid", oACFValid, 0);
`ifdef AUTOCORR_PIPE_EN
        step();
        chk("t1_hold2_ready", oReady, 0);
        chk("t1_hold2_valid", oACFValid, 0);
`endif
        step();
        chk("t1_ready_back", oReady, 1);
        chk("t1_xfer_valid", oACFValid, 1);
        set_ev(30, 20, 11, 4);
        drain("t1");

        // Short block 5, -3
        send(5, 0); send(-3, 1);
        set_ev(34, -15, 0, 0);
        drain("t2");

        // Full block of -32768, ended by the sample count
        for (int n = 0; n < 4096; n++) send(-32768, 0);
        chk("t3_count_end", oReady, 0);
        for (int k = 0; k < 13; k++) ev[k] = longint'(4096 - k) <<< 30;
        drain("t3");

        // Back-to-back blocks with downstream stalled
        iACFReady = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        send(5, 0); send(-3, 1);
        for (int c = 0; c < 4; c++) begin
            chk("t4_stall_valid", oACFValid, 1);
            chk("t4_stall_lag", oACFLag, 0);
            chk("t4_stall_acf", oACF, 30);
            chk("t4_stall_last", oACFLast, 0);
            chk("t4_stall_ready", oReady, 0);
            step();
        end
        set_ev(30, 20, 11, 4);
        drain("t4a");
        set_ev(34, -15, 0, 0);
        drain("t4b");

        // Cross-block isolation and enable freeze
        iACFReady = 1'b0;
        send(1, 0); send(1, 0); send(1, 0); send(1, 1);
        for (int g = 0; g < 20 && !oACFValid; g++) step();
        iEnable = 1'b0; iACFReady = 1'b1;
        iSample = 16'sd99; iValid = 1'b1;
        repeat (3) step();
        chk("t5_frz_lag", oACFLag, 0);
        chk("t5_frz_valid", oACFValid, 1);
        chk("t5_frz_acf", oACF, 4);
        chk("t5_frz_ready", oReady, 1);
        iEnable = 1'b1; iValid = 1'b0;
        set_ev(4, 3, 2, 1);
        drain("t5a");
        send(2, 0); send(2, 1);
        set_ev(8, 4, 0, 0);
        drain("t5b");

        // Reset mid-stream and mid-block
        iACFReady = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        send(9, 0); send(9, 0);
        iACFReady = 1'b1;
        step();
        iACFReady = 1'b0;
        chk("t6_pre_lag", oACFLag, 1);
        iReset_n = 1'b0;
        #1;
        chk("t6_rst_valid", oACFValid, 0);
        chk("t6_rst_acf", oACF, 0);
        chk("t6_rst_lag", oACFLag, 0);
        chk("t6_rst_last", oACFLast, 0);
        chk("t6_rst_ready", oReady, 0);
        step();
        iReset_n = 1'b1;
        step();
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        set_ev(30, 20, 11, 4);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
